// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator core: opcodes, sequencer
// phase encoding and the ALU-class predicate used by controller and ALU.
package cpu_pkg;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } phase_t;

    // Instructions that read an operand from memory and write the accumulator.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencer: walks each instruction through eight phases and
// decodes the datapath strobes from phase, opcode, zero and the halt flag.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int PHASES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       alu_clk,
    output logic       halt,
    output logic       instr_done
);

    localparam phase_t LAST_PHASE = phase_t'(3'(PHASES - 1));

    phase_t phase;
    phase_t phase_next;
    logic   halted;
    logic   halted_next;
    logic   active;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= S0;
            halted <= 1'b0;
        end else begin
            phase  <= phase_next;
            halted <= halted_next;
        end
    end

    // HLT advances into S4 on the same edge that sets halted, then freezes there.
    always_comb begin
        phase_next  = phase;
        halted_next = halted;
        if (ena && !halted) begin
            phase_next = (phase == LAST_PHASE) ? S0 : phase_t'(phase + 3'd1);
            if (phase == S3 && opcode == OP_HLT) begin
                halted_next = 1'b1;
            end
        end
    end

    always_comb begin
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        alu_clk     = 1'b0;
        instr_done  = 1'b0;
        halt        = halted && !rst;
        active      = !rst && ena && !halted;

        if (active) begin
            case (phase)
                S0, S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S2: begin
                end
                S3: begin
                    inc_pc = (opcode == OP_HLT);
                end
                S4: begin
                    rd          = is_alu_op(opcode);
                    alu_clk     = is_alu_op(opcode);
                    load_pc     = (opcode == OP_JMP);
                    datactl_ena = (opcode == OP_STO);
                end
                S5: begin
                    rd          = is_alu_op(opcode);
                    load_acc    = is_alu_op(opcode);
                    inc_pc      = ((opcode == OP_SKZ) && zero) || (opcode == OP_JMP);
                    load_pc     = (opcode == OP_JMP);
                    wr          = (opcode == OP_STO);
                    datactl_ena = (opcode == OP_STO);
                end
                S6: begin
                    rd          = is_alu_op(opcode);
                    datactl_ena = (opcode == OP_STO);
                end
                S7: begin
                    inc_pc     = (opcode == OP_SKZ) && zero;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed scenarios followed by
// random instruction streams with enable gaps, compared against a model.
module tb_cpu_controller;

    localparam int HLT  = 0;
    localparam int SKZ  = 1;
    localparam int ADD  = 2;
    localparam int ANDD = 3;
    localparam int XORR = 4;
    localparam int LDA  = 5;
    localparam int STO  = 6;
    localparam int JMP  = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       load_ir, inc_pc, load_pc, rd, wr, load_acc;
    logic       datactl_ena, alu_clk, halt, instr_done;

    int errors = 0;
    int checks = 0;

    // Model state: enabled cycles elapsed in the current instruction, and halt.
    int m_step   = 0;
    bit m_halted = 1'b0;

    cpu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .opcode     (opcode),
        .zero       (zero),
        .load_ir    (load_ir),
        .inc_pc     (inc_pc),
        .load_pc    (load_pc),
        .rd         (rd),
        .wr         (wr),
        .load_acc   (load_acc),
        .datactl_ena(datactl_ena),
        .alu_clk    (alu_clk),
        .halt       (halt),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Vector order: load_ir inc_pc load_pc rd wr load_acc datactl_ena alu_clk halt instr_done
    function automatic logic [9:0] expected_vec(int step, bit hlt_flag, logic r, logic e,
                                                int op, logic z);
        logic [7:0] m_load_ir, m_inc_pc, m_load_pc, m_rd, m_wr, m_load_acc;
        logic [7:0] m_datactl, m_alu_clk, m_done;
        bit alu;
        if (r) return 10'b0;
        if (hlt_flag) return 10'b00_0000_0010;
        if (!e) return 10'b0;
        alu        = (op >= ADD) && (op <= LDA);
        m_load_ir  = 8'b0000_0011;
        m_rd       = 8'b0000_0011 | (alu ? 8'b0111_0000 : 8'b0);
        m_inc_pc   = 8'b0000_0011 | ((op == HLT) ? 8'b0000_1000 : 8'b0)
                   | ((op == SKZ && z) ? 8'b1010_0000 : 8'b0)
                   | ((op == JMP) ? 8'b0010_0000 : 8'b0);
        m_load_pc  = (op == JMP) ? 8'b0011_0000 : 8'b0;
        m_wr       = (op == STO) ? 8'b0010_0000 : 8'b0;
        m_load_acc = alu ? 8'b0010_0000 : 8'b0;
        m_datactl  = (op == STO) ? 8'b0111_0000 : 8'b0;
        m_alu_clk  = alu ? 8'b0001_0000 : 8'b0;
        m_done     = 8'b1000_0000;
        return {m_load_ir[step], m_inc_pc[step], m_load_pc[step], m_rd[step], m_wr[step],
                m_load_acc[step], m_datactl[step], m_alu_clk[step], 1'b0, m_done[step]};
    endfunction

    task automatic checkOutput(input string tag);
        logic [9:0] observed;
        logic [9:0] expected;
        observed = {load_ir, inc_pc, load_pc, rd, wr, load_acc, datactl_ena, alu_clk,
                    halt, instr_done};
        expected = expected_vec(m_step, m_halted, rst, ena, int'(opcode), zero);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s step=%0d: observed=%b expected=%b", tag, m_step,
                   observed, expected);
        end
    endtask

    // One clock cycle: drive on the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic r, input logic e, input int op, input logic z,
                                 input string tag);
        @(negedge clk);
        rst    = r;
        ena    = e;
        opcode = 3'(op);
        zero   = z;
        #1;
        checkOutput(tag);
        @(posedge clk);
        #1;
        if (r) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (e && !m_halted) begin
            if (m_step == 3 && op == HLT) m_halted = 1'b1;
            m_step = (m_step + 1) % 8;
        end
    endtask

    task automatic runInstr(input int op, input logic z, input string tag);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, op, z, tag);
    endtask

    initial begin
        int op;
        logic z;

        applyStimulus(1'b1, 1'b1, ADD, 1'b0, "reset");
        applyStimulus(1'b1, 1'b1, ADD, 1'b0, "reset");

        runInstr(ADD, 1'b0, "add_flow");
        runInstr(SKZ, 1'b1, "skz_zero1");
        runInstr(SKZ, 1'b0, "skz_zero0");
        runInstr(STO, 1'b0, "sto_flow");
        runInstr(JMP, 1'b1, "jmp_flow");
        runInstr(ANDD, 1'b1, "andd_flow");
        runInstr(XORR, 1'b0, "xorr_flow");
        runInstr(LDA, 1'b0, "lda_flow");

        // ADD stalled at S4, resumed for one cycle, then reset in S5.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, ADD, 1'b0, "gap_pre");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, ADD, 1'b0, "gap_off");
        applyStimulus(1'b0, 1'b1, ADD, 1'b0, "gap_resume_s4");
        applyStimulus(1'b1, 1'b1, ADD, 1'b0, "rst_at_s5");
        runInstr(STO, 1'b0, "after_rst");

        // HLT then 20 halted cycles, some with ena low, then reset recovery.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, HLT, 1'b0, "hlt_fetch");
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, (i % 5) != 2, $urandom_range(0, 7), 1'(i), "halted");
        applyStimulus(1'b1, 1'b1, ADD, 1'b0, "halt_rst");
        runInstr(ADD, 1'b0, "post_halt");

        // Random instruction stream with enable gaps and occasional reset.
        op = ADD;
        z  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (m_step == 0) begin
                op = $urandom_range(1, 7);
                z  = 1'($urandom_range(0, 1));
            end
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 4) != 0, op, z,
                          "random");
        end

        // Random stream ending in a halt.
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1'b1, (m_step < 4) ? HLT : JMP, 1'b1, "final_hlt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction sequencer for the 8-bit accumulator RISC core. Steps every instruction through a fixed 8-phase cycle: two-byte fetch, decode, execute. Drives the PC, IR, accumulator, memory read/write and bus-driver enables. Issues the single-cycle ALU evaluate strobe consumed as `alu_clk`. Latches a sticky halt on HLT.

## Interface
Parameters:
- `PHASES`, 8: phases per instruction; fixed, not overridable in practice.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ena`  in  1  run enable; when low the sequencer freezes
- `opcode`  in  3  IR[7:5]; valid from phase S2 onward
- `zero`  in  1  accumulator==0 flag
- `load_ir`  out  1  IR byte load
- `inc_pc`  out  1  PC increment
- `load_pc`  out  1  PC load from IR address
- `rd`  out  1  memory read
- `wr`  out  1  memory write
- `load_acc`  out  1  accumulator load from ALU result
- `datactl_ena`  out  1  drive accumulator onto data bus
- `alu_clk`  out  1  one-cycle ALU evaluate strobe
- `halt`  out  1  sticky halted indication
- `instr_done`  out  1  one-cycle pulse in final phase

## Operation
- State: 3-bit phase counter S0..S7, plus 1-bit `halted` flag. Outputs are combinational decode of (phase, opcode, zero, halted, ena).
- Opcodes: HLT 000, SKZ 001, ADD 010, ANDD 011, XORR 100, LDA 101, STO 110, JMP 111. ALU-class = ADD, ANDD, XORR, LDA.
- Phase outputs (any output not listed is 0):
  - S0: rd, load_ir, inc_pc (high byte fetch)
  - S1: rd, load_ir, inc_pc (low byte fetch)
  - S2: none (decode)
  - S3: HLT → inc_pc; halted set at end of S3
  - S4: ALU-class → rd, alu_clk. JMP → load_pc. STO → datactl_ena
  - S5: ALU-class → rd, load_acc. SKZ and zero=1 → inc_pc. JMP → load_pc, inc_pc. STO → wr, datactl_ena
  - S6: ALU-class → rd. STO → datactl_ena
  - S7: SKZ and zero=1 → inc_pc. Always instr_done
- SKZ skip: two inc_pc pulses (S5, S7) step over the 2-byte next instruction. `zero` is sampled independently in each phase; the bench holds the accumulator stable across them.
- Transitions: phase advances S(n)→S(n+1) when ena=1 and halted=0; S7→S0 wrap.
- Halt: halted=1 → phase frozen at its current value; all outputs 0 except halt=1. Exit only via rst.
- ena=0: phase and halted hold; all outputs forced 0 except halt, which still reflects the halted flag.

## Timing
- Reset (rst=1 at a clock edge): phase←S0, halted←0. While rst is high all outputs are 0. rst overrides ena and halted and aborts any in-flight instruction in any phase.
- First post-reset cycle with ena=1 shows the S0 outputs.
- Each instruction takes exactly 8 enabled cycles. The ALU result is written at S5, 1 cycle after alu_clk at S4.
- HLT: S3 shows inc_pc=1 and halt=0. From the next cycle halt=1 permanently, with phase=S4 frozen.
- ena deasserted mid-instruction: resumes in the same phase with no lost or repeated strobes.
- Unknown/X opcode is not possible (3-bit full decode). Default branch outputs are all 0.

## Structure
- Shared package `cpu_pkg`: opcode localparams (HLT..JMP), phase encoding S0..S7, ALU-class predicate function. The ALU uses the same package.
- Single module. Phase counter and halted flag in one clocked process; output decode in one combinational process. No sub-module.

## Test plan
- Reset: rst=1 for 2 cycles, then ena=1 with opcode=ADD → cycle 1 shows rd=load_ir=inc_pc=1; all outputs were 0 during reset.
- ADD flow: opcode=010 → alu_clk only in S4, load_acc only in S5, rd in S0,S1,S4,S5,S6, instr_done in S7, next cycle S0 outputs again.
- SKZ: zero=1 → inc_pc in S0,S1,S5,S7 (4 pulses). zero=0 → inc_pc only in S0,S1.
- STO/JMP: STO → datactl_ena S4–S6, wr only S5. JMP → load_pc S4,S5, inc_pc S5.
- HLT: halt=1 from the cycle after S3 and all other outputs 0 for 20 cycles. rst=1 then restarts at S0.
- ena gap: deassert ena for 3 cycles at S4 of ADD → outputs 0, then alu_clk fires once on resume. Assert rst at S5 → next cycle S0, no wr/load_acc.
